alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 179 +++++++++++++++++
 tb/tb_alu_writeback.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// ALU writeback stage: one register of issue state, decimal adjust of the ALU
// result, architectural register file A/X/Y/S and the status register P.
module alu_writeback (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       RDY,
    input  logic       iss_valid,
    input  logic [1:0] iss_dst,
    input  logic [2:0] iss_upd,
    input  logic       iss_dadd,
    input  logic       iss_dsub,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       alu_hc,
    input  logic       p_load,
    input  logic [7:0] p_din,
    input  logic [2:0] flag_op,
    output logic [7:0] A,
    output logic [7:0] X,
    output logic [7:0] Y,
    output logic [7:0] S,
    output logic [7:0] P,
    output logic       wb_done
);

    localparam logic [1:0] DST_A = 2'd0;
    localparam logic [1:0] DST_X = 2'd1;
    localparam logic [1:0] DST_Y = 2'd2;
    localparam logic [1:0] DST_S = 2'd3;

    localparam logic [2:0] FOP_CLC = 3'd1;
    localparam logic [2:0] FOP_SEC = 3'd2;
    localparam logic [2:0] FOP_CLI = 3'd3;
    localparam logic [2:0] FOP_SEI = 3'd4;
    localparam logic [2:0] FOP_CLV = 3'd5;
    localparam logic [2:0] FOP_CLD = 3'd6;
    localparam logic [2:0] FOP_SED = 3'd7;

    // Flag storage order {N,V,D,I,Z,C}; the two constant-one bits of P are not stored.
    localparam int F_C = 0;
    localparam int F_Z = 1;
    localparam int F_I = 2;
    localparam int F_D = 3;
    localparam int F_V = 4;
    localparam int F_N = 5;

    // Nibble-wise BCD correction; each nibble wraps on its own, no carry between them.
    function automatic logic [7:0] dec_adjust(
        input logic [7:0] val,
        input logic       dadd,
        input logic       dsub,
        input logic       hc,
        input logic       co
    );
        logic [3:0] lo;
        logic [3:0] hi;
        lo = val[3:0];
        hi = val[7:4];
        if (dadd) begin
            if (hc) lo = lo + 4'd6;
            if (co) hi = hi + 4'd6;
        end else if (dsub) begin
            if (!hc) lo = lo + 4'd10;
            if (!co) hi = hi + 4'd10;
        end
        return {hi, lo};
    endfunction

    logic       s1_valid_q, s1_valid_d;
    logic [1:0] s1_dst_q, s1_dst_d;
    logic [2:0] s1_upd_q, s1_upd_d;
    logic       s1_dadd_q, s1_dadd_d;
    logic       s1_dsub_q, s1_dsub_d;

    logic [7:0] a_q, a_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [7:0] s_q, s_d;
    logic [5:0] flags_q, flags_d;
    logic       wb_done_q, wb_done_d;

    logic       commit;
    logic [7:0] wb_val;

    always_comb begin
        commit     = RDY & s1_valid_q;
        wb_val     = dec_adjust(alu_out, s1_dadd_q, s1_dsub_q, alu_hc, alu_co);

        s1_valid_d = RDY ? iss_valid : s1_valid_q;
        s1_dst_d   = RDY ? iss_dst   : s1_dst_q;
        s1_upd_d   = RDY ? iss_upd   : s1_upd_q;
        s1_dadd_d  = RDY ? iss_dadd  : s1_dadd_q;
        s1_dsub_d  = RDY ? iss_dsub  : s1_dsub_q;

        a_d = a_q;
        x_d = x_q;
        y_d = y_q;
        s_d = s_q;
        if (commit) begin
            case (s1_dst_q)
                DST_A:   a_d = wb_val;
                DST_X:   x_d = wb_val;
                DST_Y:   y_d = wb_val;
                DST_S:   s_d = wb_val;
                default: a_d = a_q;
            endcase
        end

        // Lowest priority first, so later assignments win per bit.
        flags_d = flags_q;
        if (RDY) begin
            case (flag_op)
                FOP_CLC: flags_d[F_C] = 1'b0;
                FOP_SEC: flags_d[F_C] = 1'b1;
                FOP_CLI: flags_d[F_I] = 1'b0;
                FOP_SEI: flags_d[F_I] = 1'b1;
                FOP_CLV: flags_d[F_V] = 1'b0;
                FOP_CLD: flags_d[F_D] = 1'b0;
                FOP_SED: flags_d[F_D] = 1'b1;
                default: flags_d = flags_q;
            endcase
        end
        if (commit) begin
            // N/Z/V follow the binary result even when the value is decimal-adjusted.
            if (s1_upd_q[0]) begin
                flags_d[F_N] = alu_n;
                flags_d[F_Z] = alu_z;
            end
            if (s1_upd_q[1]) flags_d[F_V] = alu_v;
            if (s1_upd_q[2]) flags_d[F_C] = alu_co;
        end
        if (RDY && p_load) begin
            flags_d = {p_din[7:6], p_din[3:0]};
        end

        // Not gated by RDY so the pulse drops during a stall.
        wb_done_d = commit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= 8'h00;
            x_q        <= 8'h00;
            y_q        <= 8'h00;
            s_q        <= 8'hFF;
            flags_q    <= 6'b000100;
            wb_done_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            x_q        <= x_d;
            y_q        <= y_d;
            s_q        <= s_d;
            flags_q    <= flags_d;
            wb_done_q  <= wb_done_d;
        end
    end

    // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_dst_q  <= s1_dst_d;
        s1_upd_q  <= s1_upd_d;
        s1_dadd_q <= s1_dadd_d;
        s1_dsub_q <= s1_dsub_d;
    end

    assign A       = a_q;
    assign X       = x_q;
    assign Y       = y_q;
    assign S       = s_q;
    assign P       = {flags_q[F_N], flags_q[F_V], 2'b11, flags_q[F_D],
                      flags_q[F_I], flags_q[F_Z], flags_q[F_C]};
    assign wb_done = wb_done_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus a randomized run checked
// against a register/flag-level reference model.
module tb_alu_writeback;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       RDY = 1'b1;
    logic       iss_valid = 1'b0;
    logic [1:0] iss_dst = '0;
    logic [2:0] iss_upd = '0;
    logic       iss_dadd = 1'b0;
    logic       iss_dsub = 1'b0;
    logic [7:0] alu_out = '0;
    logic       alu_co = 1'b0, alu_v = 1'b0, alu_z = 1'b0, alu_n = 1'b0, alu_hc = 1'b0;
    logic       p_load = 1'b0;
    logic [7:0] p_din = '0;
    logic [2:0] flag_op = '0;
    logic [7:0] A, X, Y, S, P;
    logic       wb_done;

    int total = 0;
    int bad = 0;

    alu_writeback dut (
        .clk(clk), .reset_n(reset_n), .RDY(RDY),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_upd(iss_upd),
        .iss_dadd(iss_dadd), .iss_dsub(iss_dsub),
        .alu_out(alu_out), .alu_co(alu_co), .alu_v(alu_v), .alu_z(alu_z),
        .alu_n(alu_n), .alu_hc(alu_hc),
        .p_load(p_load), .p_din(p_din), .flag_op(flag_op),
        .A(A), .X(X), .Y(Y), .S(S), .P(P), .wb_done(wb_done)
    );

    always #5 clk = ~clk;

    // Reference model state
    int unsigned m_reg[4];
    bit m_n, m_v, m_d, m_i, m_z, m_c;
    bit m_pv, m_padd, m_psub, m_wb;
    int unsigned m_pdst;
    bit [2:0] m_pupd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RDY = 1'b1; iss_valid = 1'b0; iss_dst = '0; iss_upd = '0;
        iss_dadd = 1'b0; iss_dsub = 1'b0; alu_out = '0;
        alu_co = 1'b0; alu_v = 1'b0; alu_z = 1'b0; alu_n = 1'b0; alu_hc = 1'b0;
        p_load = 1'b0; p_din = '0; flag_op = '0;
    endtask

    task automatic issue(input logic [1:0] dst, input logic [2:0] upd,
                         input logic dadd, input logic dsub);
        iss_valid = 1'b1; iss_dst = dst; iss_upd = upd; iss_dadd = dadd; iss_dsub = dsub;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    function automatic int unsigned bcd_fix(int unsigned v, bit add, bit sub, bit hc, bit co);
        int unsigned lo, hi;
        lo = v % 16;
        hi = v / 16;
        if (add) begin
            if (hc) lo = (lo + 6) % 16;
            if (co) hi = (hi + 6) % 16;
        end else if (sub) begin
            if (!hc) lo = (lo + 10) % 16;
            if (!co) hi = (hi + 10) % 16;
        end
        return hi * 16 + lo;
    endfunction

    function automatic logic [7:0] model_p();
        return {m_n, m_v, 2'b11, m_d, m_i, m_z, m_c};
    endfunction

    task automatic model_reset();
        m_reg[0] = 0; m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 255;
        m_n = 0; m_v = 0; m_d = 0; m_i = 1; m_z = 0; m_c = 0;
        m_pv = 0; m_wb = 0; m_pdst = 0; m_pupd = 0; m_padd = 0; m_psub = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit commit;
        commit = RDY && m_pv;
        if (RDY) begin
            case (flag_op)
                3'd1: m_c = 0;
                3'd2: m_c = 1;
                3'd3: m_i = 0;
                3'd4: m_i = 1;
                3'd5: m_v = 0;
                3'd6: m_d = 0;
                3'd7: m_d = 1;
                default: ;
            endcase
            if (commit) begin
                m_reg[m_pdst] = bcd_fix(alu_out, m_padd, m_psub, alu_hc, alu_co);
                if (m_pupd[0]) begin m_n = alu_n; m_z = alu_z; end
                if (m_pupd[1]) m_v = alu_v;
                if (m_pupd[2]) m_c = alu_co;
            end
            if (p_load) begin
                m_n = p_din[7]; m_v = p_din[6]; m_d = p_din[3];
                m_i = p_din[2]; m_z = p_din[1]; m_c = p_din[0];
            end
            m_pv = iss_valid; m_pdst = iss_dst; m_pupd = iss_upd;
            m_padd = iss_dadd; m_psub = iss_dsub;
        end
        m_wb = commit;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (A !== 8'h00) begin bad++; $display("FAIL reset_A got=%h exp=00", A); end
        total++; if (X !== 8'h00) begin bad++; $display("FAIL reset_X got=%h exp=00", X); end
        total++; if (Y !== 8'h00) begin bad++; $display("FAIL reset_Y got=%h exp=00", Y); end
        total++; if (S !== 8'hFF) begin bad++; $display("FAIL reset_S got=%h exp=ff", S); end
        total++; if (P !== 8'h34) begin bad++; $display("FAIL reset_P got=%h exp=34", P); end
        total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL reset_wb got=%b exp=0", wb_done); end
    endtask

    task automatic test_binary();
        do_reset();
        issue(2'd0, 3'b111, 1'b0, 1'b0);
        step();
        total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL bin_wb_early got=%b exp=0", wb_done); end
        iss_valid = 1'b0;
        alu_out = 8'h80; alu_n = 1'b1; alu_v = 1'b1; alu_co = 1'b0; alu_z = 1'b0;
        step();
        total++; if (A !== 8'h80) begin bad++; $display("FAIL bin_A got=%h exp=80", A); end
        total++; if (P !== 8'hF4) begin bad++; $display("FAIL bin_P got=%h exp=f4", P); end
        total++; if (wb_done !== 1'b1) begin bad++; $display("FAIL bin_wb got=%b exp=1", wb_done); end
        step();
        total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL bin_wb_after got=%b exp=0", wb_done); end
    endtask

    task automatic test_decimal_add();
        // continues from test_binary: A=80, P=F4
        idle();
        issue(2'd0, 3'b101, 1'b1, 1'b0);
        step();
        idle();
        alu_out = 8'h1A; alu_hc = 1'b1; alu_co = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
        step();
        total++; if (A !== 8'h10) begin bad++; $display("FAIL dadd_A got=%h exp=10", A); end
        total++; if (P !== 8'h74) begin bad++; $display("FAIL dadd_P got=%h exp=74", P); end
    endtask

    task automatic test_decimal_sub();
        idle();
        issue(2'd0, 3'b100, 1'b0, 1'b1);
        step();
        idle();
        alu_out = 8'h0F; alu_hc = 1'b0; alu_co = 1'b1;
        step();
        total++; if (A !== 8'h09) begin bad++; $display("FAIL dsub_A got=%h exp=09", A); end
        total++; if (P[0] !== 1'b1) begin bad++; $display("FAIL dsub_C got=%b exp=1", P[0]); end
    endtask

    task automatic test_stall();
        logic [7:0] vals[3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        do_reset();
        issue(2'd1, 3'b000, 1'b0, 1'b0);
        alu_out = 8'h55;
        step();
        idle();
        RDY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            alu_out = vals[k];
            step();
            total++; if (X !== 8'h00) begin bad++; $display("FAIL stall_X got=%h exp=00", X); end
            total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL stall_wb got=%b exp=0", wb_done); end
        end
        RDY = 1'b1;
        alu_out = 8'h44;
        step();
        total++; if (X !== 8'h44) begin bad++; $display("FAIL stall_commit_X got=%h exp=44", X); end
        total++; if (wb_done !== 1'b1) begin bad++; $display("FAIL stall_commit_wb got=%b exp=1", wb_done); end
        RDY = 1'b0;
        step();
        total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL stall_wb_drop got=%b exp=0", wb_done); end
        RDY = 1'b1;
    endtask

    task automatic test_conflict();
        do_reset();
        issue(2'd2, 3'b100, 1'b0, 1'b0);
        step();
        idle();
        alu_out = 8'h77; alu_co = 1'b1;
        p_load = 1'b1; p_din = 8'h00; flag_op = 3'd2;
        step();
        total++; if (P !== 8'h30) begin bad++; $display("FAIL conflict_P got=%h exp=30", P); end
        total++; if (Y !== 8'h77) begin bad++; $display("FAIL conflict_Y got=%h exp=77", Y); end
        idle();
    endtask

    task automatic test_flag_ops();
        logic [2:0] ops[7];
        logic [7:0] exp[7];
        ops = '{3'd2, 3'd7, 3'd3, 3'd4, 3'd1, 3'd6, 3'd5};
        exp = '{8'h35, 8'h3D, 8'h39, 8'h3D, 8'h3C, 8'h34, 8'h34};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            flag_op = ops[k];
            step();
            total++; if (P !== exp[k]) begin bad++; $display("FAIL flag_op%0d got=%h exp=%h", ops[k], P, exp[k]); end
        end
        RDY = 1'b0; flag_op = 3'd2;
        step();
        total++; if (P !== 8'h34) begin bad++; $display("FAIL flag_stall got=%h exp=34", P); end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(2'd0, 3'b000, 1'b0, 1'b0);
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) issue(k[1:0], 3'b000, 1'b0, 1'b0);
            else iss_valid = 1'b0;
            alu_out = 8'(k * 17);
            step();
            total++; if (wb_done !== 1'b1) begin bad++; $display("FAIL b2b_wb%0d got=%b exp=1", k, wb_done); end
        end
        total++; if ({A, X, Y, S} !== 32'h11223344) begin bad++; $display("FAIL b2b_regs got=%h exp=11223344", {A, X, Y, S}); end
        step();
        total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", wb_done); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        issue(2'd1, 3'b111, 1'b0, 1'b0);
        step();
        idle();
        alu_out = 8'hAB; alu_n = 1'b1; alu_v = 1'b1; alu_co = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        total++; if (X !== 8'h00 || S !== 8'hFF || P !== 8'h34) begin
            bad++; $display("FAIL midreset_regs got=%h/%h/%h exp=00/ff/34", X, S, P);
        end
        total++; if (wb_done !== 1'b0) begin bad++; $display("FAIL midreset_wb got=%b exp=0", wb_done); end
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (X !== 8'h00 || wb_done !== 1'b0) begin
                bad++; $display("FAIL midreset_release got=%h/%b exp=00/0", X, wb_done);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] got[4];
        int sel;
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            RDY = ($urandom_range(0, 3) != 0);
            iss_valid = ($urandom_range(0, 9) < 7);
            iss_dst = 2'($urandom_range(0, 3));
            iss_upd = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 2);
            iss_dadd = (sel == 1);
            iss_dsub = (sel == 2);
            alu_out = 8'($urandom_range(0, 255));
            {alu_co, alu_v, alu_z, alu_n, alu_hc} = 5'($urandom_range(0, 31));
            p_load = ($urandom_range(0, 7) == 0);
            p_din = 8'($urandom_range(0, 255));
            flag_op = 3'($urandom_range(0, 7));
            model_edge();
            step();
            got[0] = A; got[1] = X; got[2] = Y; got[3] = S;
            for (int r = 0; r < 4; r++) begin
                total++; if (got[r] !== 8'(m_reg[r])) begin
                    bad++; $display("FAIL rand_reg%0d cyc=%0d got=%h exp=%h", r, n, got[r], 8'(m_reg[r]));
                end
            end
            total++; if (P !== model_p()) begin bad++; $display("FAIL rand_P cyc=%0d got=%h exp=%h", n, P, model_p()); end
            total++; if (wb_done !== m_wb) begin bad++; $display("FAIL rand_wb cyc=%0d got=%b exp=%b", n, wb_done, m_wb); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_binary();
        test_decimal_add();
        test_decimal_sub();
        test_stall();
        test_conflict();
        test_flag_ops();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
